// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and types for the pipeline hazard sequencer
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Destination metadata tracked for a pipeline stage
    typedef struct packed {
        logic [4:0] rd;
        logic       regwen;
        logic       is_load;
    } stage_meta_t;

    // EX also remembers which source registers its instruction reads
    typedef struct packed {
        stage_meta_t meta;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rs1;
        logic        use_rs2;
    } ex_meta_t;

    // A write only matters when it is enabled and not aimed at x0
    function automatic logic eff_write(input logic [4:0] rd, input logic regwen);
        return regwen && (rd != REG_X0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// rtl/hazard_ctrl_fwd_unit.sv - forwarding source select for one EX operand
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic       ex_use_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwen,
    input  logic       mem_is_load,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwen,
    output logic [1:0] fwd_sel
);

    logic mem_hit;
    logic wb_hit;

    // MEM is the younger producer so it wins; a load in MEM has no data yet
    always_comb begin
        mem_hit = ex_use_rs && eff_write(mem_rd, mem_regwen) && (mem_rd == ex_rs) && !mem_is_load;
        wb_hit  = ex_use_rs && eff_write(wb_rd, wb_regwen) && (wb_rd == ex_rs);
        fwd_sel = FWD_RF;
        if (mem_hit) begin
            fwd_sel = FWD_MEM;
        end else if (wb_hit) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencer for the 5-stage RV32 pipeline
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwen,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    hz_state_e         state_q, state_d;
    ex_meta_t          ex_q, ex_d;
    stage_meta_t       mem_q, mem_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_regwen_q, wb_regwen_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic luh;
    logic stall_inc;
    logic flush_inc;

    fwd_unit u_fwd_a (
        .ex_rs       (ex_q.rs1),
        .ex_use_rs   (ex_q.use_rs1),
        .mem_rd      (mem_q.rd),
        .mem_regwen  (mem_q.regwen),
        .mem_is_load (mem_q.is_load),
        .wb_rd       (wb_rd_q),
        .wb_regwen   (wb_regwen_q),
        .fwd_sel     (fwd_a_sel)
    );

    fwd_unit u_fwd_b (
        .ex_rs       (ex_q.rs2),
        .ex_use_rs   (ex_q.use_rs2),
        .mem_rd      (mem_q.rd),
        .mem_regwen  (mem_q.regwen),
        .mem_is_load (mem_q.is_load),
        .wb_rd       (wb_rd_q),
        .wb_regwen   (wb_regwen_q),
        .fwd_sel     (fwd_b_sel)
    );

    // Load in EX feeding the ID instruction; after the bubble EX is empty so LSTALL never repeats
    always_comb begin
        luh = eff_write(ex_q.meta.rd, ex_q.meta.regwen) && ex_q.meta.is_load &&
              ((id_use_rs1 && (id_rs1 == ex_q.meta.rd)) ||
               (id_use_rs2 && (id_rs2 == ex_q.meta.rd))) &&
              (state_q != ST_LSTALL);
    end

    // Per-cycle priority decision; reset forces the free-running values at once
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        state_d    = ST_RUN;
        if (!rst_n) begin
            state_d = ST_RUN;
        end else if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            state_d  = ST_MWAIT;
        end else if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            state_d    = ST_RUN;
        end else if (luh) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
            state_d    = ST_LSTALL;
        end
    end

    // Shadow metadata follows the real pipeline registers
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_rd_d     = wb_rd_q;
        wb_regwen_d = wb_regwen_q;
        if (exmem_en) begin
            wb_rd_d     = mem_q.rd;
            wb_regwen_d = mem_q.regwen;
            mem_d       = ex_q.meta;
        end
        if (idex_flush) begin
            ex_d = '0;
        end else if (idex_en) begin
            ex_d.meta.rd      = id_rd;
            ex_d.meta.regwen  = id_regwen;
            ex_d.meta.is_load = id_is_load;
            ex_d.rs1          = id_rs1;
            ex_d.rs2          = id_rs2;
            ex_d.use_rs1      = id_use_rs1;
            ex_d.use_rs2      = id_use_rs2;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State register for FSM, shadow stages and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            ex_q        <= '0;
            mem_q       <= '0;
            wb_rd_q     <= '0;
            wb_regwen_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_rd_q     <= wb_rd_d;
            wb_regwen_q <= wb_regwen_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
